// File: rtl/pipeline_if_fetch_pkg.sv
// Shared definitions for the IF fetch stage and its ID-side consumer.
package pipeline_if_fetch_pkg;

  localparam int          IF_TO_ID_WD = 65;
  localparam logic [31:0] PC_INC      = 32'd4;

  typedef enum logic [1:0] {
    REQ_BOOT,
    REQ_IDLE,
    REQ_HOLD
  } req_state_e;

  function automatic logic [IF_TO_ID_WD-1:0] pack_if_id(input logic        adel,
                                                        input logic [31:0] inst,
                                                        input logic [31:0] pc);
    return {adel, inst, pc};
  endfunction

endpackage

// File: rtl/pipeline_if_fetch_fifo.sv
// Synchronous instruction buffer between the fetch bus and ID; clear wins over push/pop.
module if_inst_fifo
  import pipeline_if_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = IF_TO_ID_WD
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + ($clog2(DEPTH)+1)'(1);
        2'b01:   count <= count - ($clog2(DEPTH)+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= din;
  end

  assign empty = (count == '0);
  assign dout  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/pipeline_if_fetch.sv
// IF stage: issues fetches on the SRAM-like bus, tracks in-flight PCs and hands
// {adel_ex, inst, pc} to ID; flush/redirect discard everything still in flight.
//
// state    | meaning
// REQ_BOOT | first cycle after reset, no request driven
// REQ_IDLE | request may be raised from pc when credit allows
// REQ_HOLD | request raised but not accepted, address frozen
module pipeline_if_fetch
  import pipeline_if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter int          MAX_OUTST  = 2
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   flush,
  input  logic [31:0]            flush_pc,
  input  logic                   br_redirect,
  input  logic [31:0]            br_target,
  input  logic                   id_allowin,
  output logic                   if_id_valid,
  output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
  output logic                   inst_req,
  output logic [31:0]            inst_addr,
  input  logic                   inst_addr_ok,
  input  logic                   inst_data_ok,
  input  logic [31:0]            inst_rdata
);

  localparam int CW    = $clog2(MAX_OUTST) + 1;
  localparam int OQ_AW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int FCW   = $clog2(FIFO_DEPTH) + 1;

  function automatic logic [OQ_AW-1:0] oq_next(input logic [OQ_AW-1:0] p);
    return (p == OQ_AW'(MAX_OUTST - 1)) ? '0 : p + OQ_AW'(1);
  endfunction

  req_state_e state, state_nxt;

  logic [31:0]            pc;
  logic [31:0]            held_addr;
  logic                   held_stale;
  logic                   halt;
  logic [CW-1:0]          outst, outst_nxt;
  logic [CW-1:0]          discard, discard_nxt;
  logic [31:0]            oq_pc [MAX_OUTST];
  logic [OQ_AW-1:0]       oq_wr, oq_rd;

  logic                   restart;
  logic [31:0]            restart_pc;
  logic                   addr_fire;
  logic                   resp_drop, resp_push, adel_push;
  logic                   issue_ok, credit_ok;
  logic [7:0]             credit_used;
  logic                   fifo_push, fifo_pop, fifo_empty;
  logic [FCW-1:0]         fifo_cnt;
  logic [IF_TO_ID_WD-1:0] fifo_din;

  assign restart    = flush | br_redirect;
  assign restart_pc = flush ? flush_pc : br_target;
  assign addr_fire  = inst_req & inst_addr_ok;
  assign resp_drop  = inst_data_ok & (discard != '0);
  assign resp_push  = inst_data_ok & (discard == '0) & !restart;

  assign if_id_valid = !fifo_empty & !restart;
  assign fifo_pop    = if_id_valid & id_allowin;

  // A pop this cycle frees a slot, which keeps issue back-to-back when ID drains.
  assign credit_used = 8'(fifo_cnt) + 8'(outst) - {7'b0, fifo_pop};
  assign credit_ok   = credit_used < 8'(FIFO_DEPTH);

  assign issue_ok = (state == REQ_IDLE) && !halt && (pc[1:0] == 2'b00) &&
                    (outst < CW'(MAX_OUTST)) && credit_ok && !restart;

  // Misaligned entry waits until every live fetch ahead of it has returned.
  assign adel_push = (state == REQ_IDLE) && !halt && (pc[1:0] != 2'b00) &&
                     credit_ok && (outst == discard) && !restart && !resp_push;

  assign outst_nxt = outst + CW'(addr_fire) - CW'(inst_data_ok);

  always_comb begin
    discard_nxt = discard;
    if (restart) begin
      discard_nxt = outst_nxt;
    end else begin
      if (addr_fire && held_stale) discard_nxt = discard_nxt + CW'(1);
      if (resp_drop)               discard_nxt = discard_nxt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= REQ_BOOT;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      REQ_BOOT: state_nxt = REQ_IDLE;
      REQ_IDLE: if (issue_ok && !inst_addr_ok) state_nxt = REQ_HOLD;
      REQ_HOLD: if (inst_addr_ok) state_nxt = REQ_IDLE;
      default:  state_nxt = REQ_BOOT;
    endcase
  end

  always_comb begin
    inst_req  = 1'b0;
    inst_addr = pc;
    case (state)
      REQ_IDLE: inst_req = issue_ok;
      REQ_HOLD: begin
        inst_req  = 1'b1;
        inst_addr = held_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc         <= RESET_PC;
      held_addr  <= RESET_PC;
      held_stale <= 1'b0;
      halt       <= 1'b0;
      outst      <= '0;
      discard    <= '0;
      oq_wr      <= '0;
      oq_rd      <= '0;
    end else begin
      outst   <= outst_nxt;
      discard <= discard_nxt;
      if (restart)                        pc <= restart_pc;
      else if (addr_fire && !held_stale)  pc <= pc + PC_INC;
      if (state == REQ_IDLE && issue_ok && !inst_addr_ok) held_addr <= pc;
      if (addr_fire)                      held_stale <= 1'b0;
      else if (restart && inst_req)       held_stale <= 1'b1;
      if (restart)                        halt <= 1'b0;
      else if (adel_push)                 halt <= 1'b1;
      if (addr_fire)    oq_wr <= oq_next(oq_wr);
      if (inst_data_ok) oq_rd <= oq_next(oq_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (addr_fire) oq_pc[oq_wr] <= inst_addr;
  end

  assign fifo_push = resp_push | adel_push;
  assign fifo_din  = resp_push ? pack_if_id(1'b0, inst_rdata, oq_pc[oq_rd])
                               : pack_if_id(1'b1, 32'h0, pc);

  if_inst_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (IF_TO_ID_WD)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .clear  (restart),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .din    (fifo_din),
    .dout   (if_to_id_bus),
    .count  (fifo_cnt),
    .empty  (fifo_empty)
  );

endmodule

// File: tb/tb_pipeline_if_fetch.sv
// Bench for pipeline_if_fetch: reactive fetch bus plus an epoch-tagged scoreboard of ID output.
module tb_pipeline_if_fetch;
  import pipeline_if_fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic                   clk = 1'b0;
  logic                   resetn;
  logic                   flush;
  logic [31:0]            flush_pc;
  logic                   br_redirect;
  logic [31:0]            br_target;
  logic                   id_allowin;
  logic                   if_id_valid;
  logic [IF_TO_ID_WD-1:0] if_to_id_bus;
  logic                   inst_req;
  logic [31:0]            inst_addr;
  logic                   inst_addr_ok;
  logic                   inst_data_ok;
  logic [31:0]            inst_rdata;

  pipeline_if_fetch #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (2),
    .MAX_OUTST  (2)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .br_redirect  (br_redirect),
    .br_target    (br_target),
    .id_allowin   (id_allowin),
    .if_id_valid  (if_id_valid),
    .if_to_id_bus (if_to_id_bus),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] pc;
    int          ep;
  } bus_ent_t;

  bus_ent_t    bus_q[$];
  logic [64:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          epoch = 0;
  int          req_epoch = 0;
  bit          req_pend = 1'b0;
  logic [31:0] exp_pc = RESET_PC;
  bit          aok_en = 1'b1;
  bit          dok_en = 1'b1;

  bus_ent_t    mon_be;
  logic [64:0] mon_e;
  bit          mon_restart;
  bit          mon_fresh;

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input string tag);
    int i;
    i = 0;
    @(negedge clk);
    while (!if_id_valid && i < 40) begin
      @(negedge clk);
      i++;
    end
    chk(tag, if_id_valid, 1'b1);
  endtask

  // Bus responder: one response per cycle at most, in order, one cycle after acceptance at the earliest.
  initial begin
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if (!resetn) begin
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'h0;
      end else begin
        inst_addr_ok = aok_en;
        inst_data_ok = dok_en && (bus_q.size() > 0);
        inst_rdata   = inst_data_ok ? rdata_of(bus_q[0].addr) : 32'h0;
      end
    end
  end

  // Model: tags each accepted fetch with the current stream epoch; only current-epoch
  // responses become expected ID instructions, and a restart opens a new epoch.
  initial begin
    forever begin
      @(negedge clk);
      if (!resetn) begin
        bus_q.delete();
        exp_q.delete();
        epoch++;
        exp_pc   = RESET_PC;
        req_pend = 1'b0;
      end else begin
        mon_restart = flush || br_redirect;
        if (if_id_valid && id_allowin) begin
          if (exp_q.size() == 0) begin
            chk("id_unexpected", if_id_valid, 1'b0);
          end else begin
            mon_e = exp_q.pop_front();
            chk("id_bus", if_to_id_bus, mon_e);
          end
        end
        if (inst_req && !req_pend) req_epoch = epoch;
        if (inst_req && inst_addr_ok) begin
          mon_fresh = (req_epoch == epoch) && !mon_restart;
          if (mon_fresh) begin
            chk("req_addr", inst_addr, exp_pc);
            mon_be.pc = exp_pc;
            mon_be.ep = epoch;
            exp_pc    = exp_pc + 32'd4;
          end else begin
            mon_be.pc = inst_addr;
            mon_be.ep = -1;
          end
          mon_be.addr = inst_addr;
          bus_q.push_back(mon_be);
        end
        req_pend = inst_req && !inst_addr_ok;
        if (inst_data_ok && bus_q.size() > 0) begin
          mon_be = bus_q.pop_front();
          if (mon_be.ep == epoch && !mon_restart)
            exp_q.push_back({1'b0, rdata_of(mon_be.pc), mon_be.pc});
        end
        if (mon_restart) begin
          epoch++;
          exp_q.delete();
          exp_pc = flush ? flush_pc : br_target;
          if (exp_pc[1:0] != 2'b00) exp_q.push_back({1'b1, 32'h0, exp_pc});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] held;
    int          i;
    resetn      = 1'b0;
    flush       = 1'b0;
    flush_pc    = 32'h0;
    br_redirect = 1'b0;
    br_target   = 32'h0;
    id_allowin  = 1'b1;
    #12;
    chk("rst_valid", if_id_valid, 1'b0);
    chk("rst_bus", if_to_id_bus, 65'h0);
    chk("rst_req", inst_req, 1'b0);
    chk("rst_addr", inst_addr, RESET_PC);
    @(posedge clk);
    #1 resetn = 1'b1;

    // Streaming: one instruction per cycle once the first arrives.
    wait_valid("t1_first_valid");
    chk("t1_first_pc", if_to_id_bus[31:0], RESET_PC);
    repeat (8) begin
      @(negedge clk);
      chk("t1_no_gap", if_id_valid, 1'b1);
    end

    // ID stall: buffer fills, requests stop, nothing lost afterwards.
    @(posedge clk);
    #1 id_allowin = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k >= 2) chk("t2_req_low", inst_req, 1'b0);
      chk("t2_held_valid", if_id_valid, 1'b1);
    end
    @(posedge clk);
    #1 id_allowin = 1'b1;
    cyc(4);

    // Flush with two fetches outstanding.
    dok_en = 1'b0;
    cyc(5);
    @(negedge clk);
    chk("t3_outst_cap", inst_req, 1'b0);
    @(posedge clk);
    #1;
    flush    = 1'b1;
    flush_pc = 32'h8000_0180;
    @(posedge clk);
    #1;
    flush  = 1'b0;
    dok_en = 1'b1;
    wait_valid("t3_valid");
    chk("t3_first_pc", if_to_id_bus[31:0], 32'h8000_0180);
    cyc(6);

    // Flush while a request is held without acceptance.
    aok_en = 1'b0;
    i = 0;
    @(negedge clk);
    while (!inst_req && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk("t4_req_raised", inst_req, 1'b1);
    held = inst_addr;
    @(posedge clk);
    #1;
    flush    = 1'b1;
    flush_pc = 32'h8000_0200;
    @(posedge clk);
    #1 flush = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t4_req_hold", inst_req, 1'b1);
      chk("t4_addr_hold", inst_addr, held);
    end
    @(posedge clk);
    #1 aok_en = 1'b1;
    wait_valid("t4_valid");
    chk("t4_first_pc", if_to_id_bus[31:0], 32'h8000_0200);
    cyc(4);

    // Redirect to a misaligned target: one adel entry, then silence until flush.
    br_redirect = 1'b1;
    br_target   = 32'h8000_0002;
    @(posedge clk);
    #1 br_redirect = 1'b0;
    wait_valid("t5_valid");
    chk("t5_adel", if_to_id_bus, {1'b1, 32'h0, 32'h8000_0002});
    repeat (6) begin
      @(negedge clk);
      chk("t5_no_req", inst_req, 1'b0);
      chk("t5_no_valid", if_id_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    flush    = 1'b1;
    flush_pc = 32'h8000_0300;
    @(posedge clk);
    #1 flush = 1'b0;
    wait_valid("t5_resume");
    chk("t5_resume_pc", if_to_id_bus[31:0], 32'h8000_0300);
    cyc(3);

    // Asynchronous reset in the middle of a burst.
    @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    chk("rst2_valid", if_id_valid, 1'b0);
    chk("rst2_bus", if_to_id_bus, 65'h0);
    chk("rst2_req", inst_req, 1'b0);
    chk("rst2_addr", inst_addr, RESET_PC);
    cyc(2);
    resetn = 1'b1;
    wait_valid("t6_valid");
    chk("t6_first_pc", if_to_id_bus[31:0], RESET_PC);
    cyc(5);

    // Drain: stop accepting and let every expected instruction reach ID.
    aok_en = 1'b0;
    i = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || bus_q.size() != 0) && i < 40) begin
      @(negedge clk);
      i++;
    end
    chk("drain_exp", exp_q.size(), 0);
    chk("drain_bus", bus_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
